// File: rtl/fc_neuron.sv
// Fully-connected output neuron: 8 pixel*weight lanes, 2-stage pipeline.
// Stage 1 registers the products, stage 2 sums, clamps and registers result.
module fc_neuron #(
   parameter int N_KERNELS      = 2,
   parameter int PIX_PER_KERNEL = 4,
   parameter int DATA_W         = 8,
   parameter int SHIFT          = 7
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [N_KERNELS*PIX_PER_KERNEL*DATA_W-1:0] pooledPixelArray,
   input  logic [N_KERNELS*PIX_PER_KERNEL*DATA_W-1:0] weight,
   output logic [DATA_W-1:0]                          result
);

   localparam int LANES  = N_KERNELS * PIX_PER_KERNEL;
   localparam int PROD_W = 2 * DATA_W + 1;
   localparam int SUM_W  = PROD_W + $clog2(LANES);
   localparam int EXT_W  = PROD_W - DATA_W;
   localparam int SEXT_W = SUM_W - PROD_W;

   localparam logic [SUM_W-1:0] SAT =
      {{(SUM_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

   logic signed [PROD_W-1:0] w_prod [LANES];
   logic signed [PROD_W-1:0] r_prod [LANES];
   logic signed [SUM_W-1:0]  w_sum;
   logic [SUM_W-1:0]         w_shift;
   logic [DATA_W-1:0]        w_act;
   logic [DATA_W-1:0]        r_result;

   // Unsigned pixel times signed weight, both widened to the product width
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         logic [PROD_W-1:0] px;
         logic [PROD_W-1:0] wt;
         px = {{EXT_W{1'b0}}, pooledPixelArray[DATA_W*i +: DATA_W]};
         wt = {{EXT_W{weight[DATA_W*i+DATA_W-1]}},
               weight[DATA_W*i +: DATA_W]};
         w_prod[i] = $signed(px) * $signed(wt);
      end
   end

   // Stage 1: capture all lane products
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LANES; i++) r_prod[i] <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) r_prod[i] <= w_prod[i];
      end
   end

   // Sign-extended adder tree; accumulator is wide enough to never wrap
   always_comb begin
      w_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         w_sum = w_sum +
            {{SEXT_W{r_prod[i][PROD_W-1]}}, r_prod[i]};
      end
   end

   // Activation: zero for non-positive sums, else shift and saturate
   always_comb begin
      w_shift = w_sum >> SHIFT;
      w_act   = '0;
      if (w_sum[SUM_W-1] || (w_sum == '0)) begin
         w_act = '0;
      end else if (w_shift > SAT) begin
         w_act = {DATA_W{1'b1}};
      end else begin
         w_act = w_shift[DATA_W-1:0];
      end
   end

   // Stage 2: register the activation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_result <= '0;
      else     r_result <= w_act;
   end

   assign result = r_result;

endmodule

// File: tb/tb_fc_neuron.sv
// Scoreboard bench for fc_neuron: stimulus pushes expected results,
// a monitor pops them when the 2-cycle-delayed output is due.
module tb_fc_neuron;

   typedef struct {
      logic [7:0] v;
      string      n;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] pix = '0;
   logic [63:0] wt  = '0;
   logic [7:0]  result;

   logic issue = 1'b0;
   logic vp0   = 1'b0;
   logic vp1   = 1'b0;
   exp_t exp_q[$];

   int checks   = 0;
   int failures = 0;

   fc_neuron dut (
      .clk              (clk),
      .rst              (rst),
      .pooledPixelArray (pix),
      .weight           (wt),
      .result           (result)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] fill(input logic [7:0] v);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = v;
      return r;
   endfunction

   task automatic check(input string nm, input logic [7:0] act,
                        input logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: result=%0d expected=%0d", nm, act, req);
      end
   endtask

   task automatic send(input logic [63:0] p, input logic [63:0] w,
                       input logic [7:0] e, input string nm);
      exp_t x;
      @(negedge clk);
      pix   = p;
      wt    = w;
      issue = 1'b1;
      x.v   = e;
      x.n   = nm;
      exp_q.push_back(x);
   endtask

   // Monitor: output for an input sampled at edge n is due after edge n+1
   always @(posedge clk) begin
      if (rst) begin
         vp0 = 1'b0;
         vp1 = 1'b0;
         exp_q.delete();
      end else begin
         exp_t x;
         vp1 = vp0;
         vp0 = issue;
         #1;
         if (vp1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL scoreboard_underflow: result=%0d", result);
            end else begin
               x = exp_q.pop_front();
               check(x.n, result, x.v);
            end
         end
      end
   end

   initial begin
      logic [63:0] p;
      logic [63:0] w;
      bit seen;
      #3;
      check("reset_state", result, 8'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_release_zero", result, 8'd0);

      send(fill(8'd1), fill(8'h10), 8'd1, "basic_sum");
      send(fill(8'd255), fill(8'h7F), 8'd255, "sat_max");
      send(fill(8'd10), fill(8'h80), 8'd0, "clamp_min");

      p = 64'h10;
      send(p, fill(8'h08), 8'd1, "b2b_w08");
      send(p, fill(8'h10), 8'd2, "b2b_w10");
      send(p, fill(8'hF8), 8'd0, "b2b_wF8");
      send(p, fill(8'h01), 8'd0, "b2b_w01");

      send(64'h02020202_02020202, 64'h02020202_FEFEFEFE, 8'd0, "kernel_order");
      p = '0;
      p = 64'h40404040_40404040;
      send(p, 64'h02020202_FEFEFEFE, 8'd0, "kernel_order_64");
      send(64'h32323232_64646464, 64'hF0F0F0F0_20202020, 8'd75, "mixed_sign");
      send(64'h00000000_000001FF, fill(8'h7F), 8'd254, "just_below_sat");
      send(64'h00000000_000103FF, fill(8'h7F), 8'd255, "sat_at_256");

      p = 64'hC8000000_00000000;
      w = fill(8'h7F);
      w[63:56] = 8'h40;
      send(p, w, 8'd100, "lane7_a");
      send(p, w, 8'd100, "lane7_b");
      send(p, w, 8'd100, "lane7_c");

      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(posedge clk);
         #2;
         if (result == 8'd100) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL wait_for_100: result=%0d expected=100", result);
      end

      rst   = 1'b1;
      issue = 1'b0;
      pix   = '0;
      wt    = '0;
      #1;
      check("async_reset", result, 8'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_released", result, 8'd0);

      send(64'd0, 64'd0, 8'd0, "zero_after_rst_a");
      send(64'd0, 64'd0, 8'd0, "zero_after_rst_b");
      send(64'd0, 64'd0, 8'd0, "zero_after_rst_c");

      @(negedge clk);
      issue = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: pending=%0d expected=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fc_neuron.md
FC_NEURON -- requirements
Module: fc_neuron

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N_KERNELS, 2: number of pooled kernel maps feeding the neuron.
- PIX_PER_KERNEL, 4: pooled pixels per kernel.
- DATA_W, 8: pixel/weight/result width.
- SHIFT, 7: right-shift applied to the positive sum before saturation.
REQ-002 Ports (name, direction, width, meaning), one per line, with the clock and reset first:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- pooledPixelArray, input, 64 (N_KERNELS*PIX_PER_KERNEL*DATA_W): packed unsigned pixels; lane i = bits [8i+7:8i], i = 0..7; kernel 0 occupies [63:32], kernel 1 occupies [31:0].
- weight, input, 64: packed two's-complement signed weights; lane i = bits [8i+7:8i]; weight lane i pairs with pixel lane i.
- result, output, 8: registered unsigned neuron activation.
REQ-003 No handshake: inputs are sampled on every rising edge, and a new result is produced every cycle.

Function
REQ-004 Stage 1 (rising edge n): register the 8 products p_i = unsigned(pixel_i) * signed(weight_i); each product is 17-bit signed, range -32640..32385.
REQ-005 Stage 2 (rising edge n+1): sum the 8 registered products into a 20-bit signed accumulator with no overflow (range -261120..259080), then apply the activation and register it into result.
REQ-006 Activation:
- sum <= 0 gives result = 0.
- Otherwise r = sum >> SHIFT (logical shift on the positive value).
- result = 255 if r > 255, else r[7:0].
REQ-007 Latency is exactly 2 rising edges: result reflects the inputs sampled at edge n after edge n+1, and holds until edge n+2.
REQ-008 Throughput is one input set per cycle.
- Inputs may change every cycle; e.g., the weight changes each cycle while the pixels are held for 4 cycles.
- Each result corresponds exactly to its own sampled pixel/weight pair; there is no cross-cycle mixing.
REQ-009 No accumulation across cycles, no bias and no internal state other than the 2 pipeline register stages.
REQ-010 Width rules: products are sign-extended before addition, and the saturation compare is done on the full-width shifted value.
REQ-011 Boundary: the all-maximum input (pixels 255, weights 0x7F) saturates to 255, and the all-minimum weight input (0x80) yields 0; there is no wrap-around in either case.

Reset
REQ-012 While rst = 1, result and all stage-1/stage-2 registers are forced to 0 immediately, independent of clk.
REQ-013 After rst deasserts, the first valid result appears 2 edges after the first sampled input; until then result = 0.
REQ-014 Reset asserted mid-stream discards all in-flight products, with no partial result emitted.

Verification
REQ-015 Reset mid-operation:
- Stimulus: assert rst between clock edges while result = 100.
- Required response: result = 0 before the next edge.
- Then, with all inputs 0 after release, result stays 0.
REQ-016 Basic sum:
- Stimulus: all pixels = 1, all weights = 0x10.
- Required response: sum = 128, result = 1 two edges later.
REQ-017 Saturation and clamp, as two separate runs:
- Run 1: all pixels = 255, weights = 0x7F; required response: sum = 259080, result = 255.
- Run 2: pixels = 10, weights = 0x80; required response: result = 0.
REQ-018 Back-to-back weight change:
- Stimulus: pixels held at 16; weights step each cycle through 0x08, 0x10, 0xF8, 0x01.
- Required response: result = 1, 2, 0, 0 on consecutive cycles, starting 2 edges after the first weight.
REQ-019 Lane mapping:
- Stimulus: only pixel lane 7 (bits 63:56) = 200, weight lane 7 = 0x40; lanes 0..6 have pixels 0 with weights 0x7F.
- Required response: result = 100.
REQ-020 Kernel ordering:
- Stimulus: kernel 0 pixels (lanes 4..7) = 64 with weights 0x02; kernel 1 pixels = 64 with weights 0xFE.
- Required response: sum = 0, result = 0.
